// File: rtl/jpeg_cone_pkg.sv
// Shared types and the per-lane AOI322/OAI322 cone evaluation.
package jpeg_cone_pkg;

  typedef enum logic {
    CONE_AOI = 1'b0,
    CONE_OAI = 1'b1
  } cone_mode_e;

  // One lane of the cone. Lanes are independent, so callers iterate over
  // their own width; this keeps the package free of a width parameter.
  function automatic logic cone_eval(
    input cone_mode_e mode,
    input logic       a,
    input logic       b,
    input logic       c,
    input logic       d,
    input logic       e
  );
    logic p, q, r;
    p = b & d;
    q = ~b;
    r = ~d;
    if (mode == CONE_AOI) begin
      cone_eval = ~((a & b & c) | (e & r) | (p & q));
    end else begin
      cone_eval = ~((a | b | c) & (e | r) & (p | q));
    end
  endfunction

endpackage

// File: rtl/jpeg_cone_pipe_stage.sv
// One valid/ready register slice of the cone result pipeline.
module jpeg_cone_pipe_stage #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_load,
  input  logic             i_valid,
  input  logic [WIDTH-1:0] i_data,
  output logic             o_valid,
  output logic [WIDTH-1:0] o_data
);

  logic             r_valid;
  logic [WIDTH-1:0] r_data;

  // Capture upstream slot on load; a bubble only clears valid, data is kept.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid <= 1'b0;
      r_data  <= '0;
    end else if (i_load) begin
      r_valid <= i_valid;
      if (i_valid) begin
        r_data <= i_data;
      end
    end
  end

  assign o_valid = r_valid;
  assign o_data  = r_data;

endmodule

// File: rtl/jpeg_cone_aoi_pipe.sv
// WIDTH-lane AOI322/OAI322 cone feeding a DEPTH-stage valid/ready pipeline
// with a wrapping delivered-result counter.
module jpeg_cone_aoi_pipe
  import jpeg_cone_pkg::*;
#(
  parameter int unsigned WIDTH   = 8,
  parameter int unsigned DEPTH   = 3,
  parameter int unsigned COUNT_W = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic               in_mode,
  input  logic [WIDTH-1:0]   in_d0,
  input  logic [WIDTH-1:0]   in_d1,
  input  logic [WIDTH-1:0]   in_d2,
  input  logic [WIDTH-1:0]   in_d3,
  input  logic [WIDTH-1:0]   in_d4,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   out_y,
  output logic [COUNT_W-1:0] out_count
);

  logic [DEPTH:0]   w_valid;
  logic [WIDTH-1:0] w_data [DEPTH+1];
  logic [DEPTH:1]   w_load;
  logic [WIDTH-1:0] w_eval;
  logic [COUNT_W-1:0] r_count;

  // Lane-wise cone evaluation of the presented operands.
  always_comb begin
    w_eval = '0;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      w_eval[i] = cone_eval(cone_mode_e'(in_mode),
                            in_d0[i], in_d1[i], in_d2[i], in_d3[i], in_d4[i]);
    end
  end

  assign w_valid[0] = in_valid;
  assign w_data[0]  = w_eval;

  // Ready chain from the output back to stage 1: a stage loads when it is
  // empty or its content moves on (the next stage loads / consumer accepts).
  always_comb begin
    logic w_take;
    w_take = out_ready;
    w_load = '0;
    for (int unsigned k = DEPTH; k > 0; k--) begin
      w_load[k] = ~w_valid[k] | w_take;
      w_take    = w_load[k];
    end
  end

  for (genvar k = 1; k <= DEPTH; k++) begin : g_stage
    jpeg_cone_pipe_stage #(
      .WIDTH(WIDTH)
    ) u_stage (
      .clk    (clk),
      .rst    (rst),
      .i_load (w_load[k]),
      .i_valid(w_valid[k-1]),
      .i_data (w_data[k-1]),
      .o_valid(w_valid[k]),
      .o_data (w_data[k])
    );
  end

  // Count results handed to the consumer, wrapping naturally.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_count <= '0;
    end else if (w_valid[DEPTH] && out_ready) begin
      r_count <= r_count + COUNT_W'(1);
    end
  end

  assign in_ready  = w_load[1] & ~rst;
  assign out_valid = w_valid[DEPTH];
  assign out_y     = w_data[DEPTH];
  assign out_count = r_count;

endmodule

// File: tb/tb_jpeg_cone_aoi_pipe.sv
// Directed-vector and scoreboard bench for jpeg_cone_aoi_pipe.
module tb_jpeg_cone_aoi_pipe;

  localparam int unsigned W  = 8;
  localparam int unsigned D  = 3;
  localparam int unsigned CW = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid, in_ready, in_mode;
  logic [W-1:0]  in_d0, in_d1, in_d2, in_d3, in_d4;
  logic          out_valid, out_ready;
  logic [W-1:0]  out_y;
  logic [CW-1:0] out_count;

  logic          wr_rst, wr_iv, wr_ir, wr_ov, wr_or;
  logic [W-1:0]  wr_y;
  logic [3:0]    wr_count;

  always #5 clk = ~clk;

  jpeg_cone_aoi_pipe #(.WIDTH(W), .DEPTH(D), .COUNT_W(CW)) u_dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_mode(in_mode), .in_d0(in_d0), .in_d1(in_d1), .in_d2(in_d2),
    .in_d3(in_d3), .in_d4(in_d4), .out_valid(out_valid),
    .out_ready(out_ready), .out_y(out_y), .out_count(out_count)
  );

  jpeg_cone_aoi_pipe #(.WIDTH(W), .DEPTH(D), .COUNT_W(4)) u_wrap (
    .clk(clk), .rst(wr_rst), .in_valid(wr_iv), .in_ready(wr_ir),
    .in_mode(1'b0), .in_d0(8'h00), .in_d1(8'h00), .in_d2(8'h00),
    .in_d3(8'h00), .in_d4(8'h00), .out_valid(wr_ov),
    .out_ready(wr_or), .out_y(wr_y), .out_count(wr_count)
  );

  typedef struct {
    logic         m;
    logic [W-1:0] d0, d1, d2, d3, d4, y;
  } vec_t;

  vec_t         tbl [8];
  int           checks = 0;
  int           errors = 0;
  logic [W-1:0] q [$];
  int unsigned  accepts, xfers;

  // Reduced forms: AOI drops the always-zero P&Q term, OAI uses P|Q = ~b|d.
  function automatic logic [W-1:0] ref_y(input logic m, input logic [W-1:0] a, b, c, d, e);
    if (!m) return ~((a & b & c) | (e & ~d));
    return ~((a | b | c) & (e | ~d) & (~b | d));
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic rand_in(input logic v, input logic m);
    in_valid = v;
    in_mode  = m;
    in_d0 = W'($urandom); in_d1 = W'($urandom); in_d2 = W'($urandom);
    in_d3 = W'($urandom); in_d4 = W'($urandom);
  endtask

  // Called at a falling edge with inputs driven; samples between edges.
  task automatic tick();
    logic [W-1:0] e;
    #2;
    if (in_valid && in_ready) begin
      q.push_back(ref_y(in_mode, in_d0, in_d1, in_d2, in_d3, in_d4));
      accepts++;
    end
    if (out_valid && out_ready) begin
      xfers++;
      if (q.size() == 0) begin
        chk("extra_output", 32'd1, 32'd0);
      end else begin
        e = q.pop_front();
        chk("order_y", 32'(out_y), 32'(e));
      end
    end
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    q.delete();
    accepts = 0;
    xfers   = 0;
  endtask

  initial begin
    int lat;
    tbl[0] = '{1'b0, 8'hFF, 8'hFF, 8'hFF, 8'h00, 8'h00, 8'h00};
    tbl[1] = '{1'b1, 8'h00, 8'h00, 8'h00, 8'hAA, 8'h55, 8'hFF};
    tbl[2] = '{1'b1, 8'hFF, 8'h0F, 8'h00, 8'hFF, 8'hFF, 8'h00};
    tbl[3] = '{1'b0, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'hFF};
    tbl[4] = '{1'b0, 8'hF0, 8'hCC, 8'hAA, 8'h0F, 8'hFF, 8'h0F};
    tbl[5] = '{1'b1, 8'h00, 8'hF0, 8'h00, 8'hCC, 8'h00, 8'hFF};
    tbl[6] = '{1'b1, 8'h01, 8'h00, 8'h00, 8'h00, 8'h00, 8'hFE};
    tbl[7] = '{1'b0, 8'hFF, 8'hFF, 8'h0F, 8'h3C, 8'hC3, 8'h30};

    rst = 1'b1; out_ready = 1'b1;
    wr_rst = 1'b1; wr_iv = 1'b0; wr_or = 1'b1;
    accepts = 0; xfers = 0;
    rand_in(1'b1, 1'b0);  // presented during reset, must be dropped
    @(negedge clk);
    @(negedge clk);
    #2;
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_y", 32'(out_y), 32'd0);
    chk("rst_out_count", 32'(out_count), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    in_valid = 1'b0;

    // Directed table: one transaction at a time, latency and count checked.
    for (int i = 0; i < 8; i++) begin
      in_valid = 1'b1; in_mode = tbl[i].m;
      in_d0 = tbl[i].d0; in_d1 = tbl[i].d1; in_d2 = tbl[i].d2;
      in_d3 = tbl[i].d3; in_d4 = tbl[i].d4;
      #2 chk("tbl_in_ready", 32'(in_ready), 32'd1);
      @(negedge clk);
      in_valid = 1'b0;
      lat = 1;
      while (!out_valid && lat < 20) begin
        @(negedge clk);
        lat++;
      end
      chk("tbl_latency", 32'(lat), 32'(D));
      chk("tbl_out_y", 32'(out_y), 32'(tbl[i].y));
      @(negedge clk);
      chk("tbl_out_count", 32'(out_count), 32'(i + 1));
    end

    // AOI streaming at full throughput, random operands.
    do_reset();
    for (int i = 0; i < 2000; i++) begin
      rand_in(1'b1, 1'b0);
      tick();
    end
    in_valid = 1'b0;
    repeat (D + 2) tick();
    chk("aoi_accepts", accepts, 32'd2000);
    chk("aoi_drained", 32'(q.size()), 32'd0);
    chk("aoi_count", 32'(out_count), 32'(2000));

    // Backpressure: fill with out_ready low, then release.
    do_reset();
    out_ready = 1'b0;
    for (int i = 0; i < 6; i++) begin
      rand_in(1'b1, 1'($urandom));
      tick();
    end
    rand_in(1'b1, 1'($urandom));
    #1;
    chk("bp_accepts", accepts, 32'(D));
    chk("bp_full_ready", 32'(in_ready), 32'd0);
    out_ready = 1'b1;
    #1;
    chk("bp_release_ready", 32'(in_ready), 32'd1);
    for (int i = 0; i < 40; i++) begin
      if (accepts >= 10) in_valid = 1'b0;
      tick();
      if (accepts < 10) rand_in(1'b1, 1'($urandom));
    end
    chk("bp_accepts_total", accepts, 32'd10);
    chk("bp_xfers", xfers, 32'd10);
    chk("bp_count", 32'(out_count), 32'd10);

    // Random valid/ready toggling with scoreboard.
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      rand_in(1'($urandom), 1'($urandom));
      out_ready = 1'($urandom);
      tick();
    end
    in_valid = 1'b0; out_ready = 1'b1;
    repeat (D + 2) tick();
    chk("rnd_drained", 32'(q.size()), 32'd0);
    chk("rnd_count", 32'(out_count), 32'(xfers[CW-1:0]));

    // Reset with a full pipe discards everything.
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      rand_in(1'b1, 1'b0);
      tick();
    end
    chk("full_before_rst", 32'(in_ready), 32'd0);
    rst = 1'b1;
    #1 chk("rst_ready_low", 32'(in_ready), 32'd0);
    @(negedge clk);
    chk("rst_full_valid", 32'(out_valid), 32'd0);
    chk("rst_full_count", 32'(out_count), 32'd0);
    chk("rst_full_y", 32'(out_y), 32'd0);
    rst = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    q.delete();
    for (int i = 0; i < 5; i++) begin
      #2 chk("no_stale_out", 32'(out_valid), 32'd0);
      @(negedge clk);
    end

    // Counter wrap on a 4-bit counter instance: 17 transfers leave 1.
    wr_rst = 1'b0;
    begin
      int wacc, wx;
      wacc = 0; wx = 0;
      for (int i = 0; i < 30; i++) begin
        wr_iv = (wacc < 17);
        #2;
        if (wr_iv && wr_ir) wacc++;
        if (wr_ov && wr_or) wx++;
        @(negedge clk);
      end
      chk("wrap_xfers", 32'(wx), 32'd17);
      chk("wrap_count", 32'(wr_count), 32'd1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
